// File: rtl/axis_keep_snooper.sv
// Passive AXI-Stream snooper: stores accepted beats into a claimed packet buffer,
// reporting per-beat byte counts, total packet length and overflow truncation.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no buffer held; claim one whenever rdy_for_sn is high
// SKIP    | buffer held; discarding the tail of a packet already in flight
// CAPTURE | buffer held; writing beats, accumulating the byte length
// FULL    | buffer exhausted; discarding beats until TLAST, length frozen
module axis_keep_snooper #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 9,
   parameter int INC_WIDTH  = 8,
   parameter int LEN_WIDTH  = 16,
   parameter int PESS       = 0,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] sn_TDATA,
   input  logic [KEEP_WIDTH-1:0] sn_TKEEP,
   input  logic                  sn_TVALID,
   input  logic                  sn_TREADY,
   input  logic                  sn_TLAST,
   output logic [ADDR_WIDTH-1:0] sn_addr,
   output logic [DATA_WIDTH-1:0] sn_wr_data,
   output logic                  sn_wr_en,
   output logic [INC_WIDTH-1:0]  sn_byte_inc,
   output logic [LEN_WIDTH-1:0]  sn_len,
   output logic                  sn_trunc,
   output logic                  sn_done,
   input  logic                  rdy_for_sn,
   output logic                  rdy_for_sn_ack
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SKIP    = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_FULL    = 2'd3
   } state_t;

   localparam int                    LSUM_W   = LEN_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

   logic [DATA_WIDTH-1:0] t_data;
   logic [KEEP_WIDTH-1:0] t_keep;
   logic                  t_valid;
   logic                  t_ready;
   logic                  t_last;

   generate
      if (PESS != 0) begin : g_pess
         logic [DATA_WIDTH-1:0] t_data_q, t_data_d;
         logic [KEEP_WIDTH-1:0] t_keep_q, t_keep_d;
         logic                  t_valid_q, t_valid_d;
         logic                  t_ready_q, t_ready_d;
         logic                  t_last_q, t_last_d;

         always_comb begin
            t_data_d  = sn_TDATA;
            t_keep_d  = sn_TKEEP;
            t_valid_d = sn_TVALID;
            t_ready_d = sn_TREADY;
            t_last_d  = sn_TLAST;
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               t_data_q  <= '0;
               t_keep_q  <= '0;
               t_valid_q <= 1'b0;
               t_ready_q <= 1'b0;
               t_last_q  <= 1'b0;
            end else begin
               t_data_q  <= t_data_d;
               t_keep_q  <= t_keep_d;
               t_valid_q <= t_valid_d;
               t_ready_q <= t_ready_d;
               t_last_q  <= t_last_d;
            end
         end

         assign t_data  = t_data_q;
         assign t_keep  = t_keep_q;
         assign t_valid = t_valid_q;
         assign t_ready = t_ready_q;
         assign t_last  = t_last_q;
      end else begin : g_direct
         assign t_data  = sn_TDATA;
         assign t_keep  = sn_TKEEP;
         assign t_valid = sn_TVALID;
         assign t_ready = sn_TREADY;
         assign t_last  = sn_TLAST;
      end
   endgenerate

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;

   logic                  beat;
   logic                  last;
   logic [INC_WIDTH-1:0]  inc;
   logic [LSUM_W-1:0]     len_sum;
   logic [LEN_WIDTH-1:0]  len_sat;

   assign beat = t_valid & t_ready;
   assign last = beat & t_last;

   always_comb begin
      inc = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         inc = inc + INC_WIDTH'(t_keep[i]);
      end
   end

   assign len_sum = {1'b0, len_q} + LSUM_W'(inc);
   assign len_sat = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];

   assign sn_addr     = addr_q;
   assign sn_wr_data  = t_data;
   assign sn_byte_inc = inc;

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      len_d          = len_q;
      sn_wr_en       = 1'b0;
      sn_done        = 1'b0;
      sn_trunc       = 1'b0;
      sn_len         = '0;
      rdy_for_sn_ack = 1'b0;
      // Reset cycles produce no strobes even though the state register lags by a cycle.
      if (!rst) begin
         case (state_q)
            ST_IDLE: begin
               rdy_for_sn_ack = rdy_for_sn;
               if (rdy_for_sn && last) begin
                  state_d = ST_CAPTURE;
               end else if (rdy_for_sn) begin
                  state_d = ST_SKIP;
               end
            end
            ST_SKIP: begin
               if (last) begin
                  state_d = ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               sn_wr_en = beat && (inc != '0);
               if (beat) begin
                  len_d = len_sat;
               end
               if (sn_wr_en) begin
                  if (addr_q == ADDR_MAX && !t_last) begin
                     state_d = ST_FULL;
                  end else begin
                     addr_d = addr_q + ADDR_WIDTH'(1);
                  end
               end
               if (last) begin
                  sn_done = 1'b1;
                  sn_len  = len_sat;
               end
            end
            ST_FULL: begin
               if (last) begin
                  sn_done  = 1'b1;
                  sn_trunc = 1'b1;
                  sn_len   = len_q;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         // A ready buffer at packet end is claimed at once so the next packet is not missed.
         if (sn_done) begin
            addr_d         = '0;
            len_d          = '0;
            rdy_for_sn_ack = rdy_for_sn;
            state_d        = rdy_for_sn ? ST_CAPTURE : ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
      end
   end

endmodule

// File: tb/tb_axis_keep_snooper.sv
// Bench for axis_keep_snooper: one stimulus stream drives a default instance, a 4-word
// buffer instance and a registered-input instance, each with its own expected-event queue.
module tb_axis_keep_snooper;

   localparam logic [2:0] W_D = 3'b001;
   localparam logic [2:0] W_S = 3'b010;
   localparam logic [2:0] W_P = 3'b100;
   localparam logic [2:0] W_ALL = 3'b111;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tvalid, tready, tlast, rdy;
   logic [63:0] cur_data;

   logic [8:0]  addr_d, addr_p;
   logic [1:0]  addr_s;
   logic [63:0] wdata_d, wdata_s, wdata_p;
   logic        wen_d, wen_s, wen_p;
   logic [7:0]  inc_d, inc_s, inc_p;
   logic [15:0] len_d, len_s, len_p;
   logic        trunc_d, trunc_s, trunc_p;
   logic        done_d, done_s, done_p;
   logic        ack_d, ack_s, ack_p;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct packed {
      int          cyc;
      logic        wr;
      logic [8:0]  addr;
      logic [7:0]  inc;
      logic [63:0] data;
      logic        dn;
      logic [15:0] len;
      logic        tr;
      logic        ak;
   } ev_t;

   ev_t q_d[$];
   ev_t q_s[$];
   ev_t q_p[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axis_keep_snooper #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .PESS(0)) dut_d (
      .clk(clk), .rst(rst), .sn_TDATA(tdata), .sn_TKEEP(tkeep), .sn_TVALID(tvalid),
      .sn_TREADY(tready), .sn_TLAST(tlast), .sn_addr(addr_d), .sn_wr_data(wdata_d),
      .sn_wr_en(wen_d), .sn_byte_inc(inc_d), .sn_len(len_d), .sn_trunc(trunc_d),
      .sn_done(done_d), .rdy_for_sn(rdy), .rdy_for_sn_ack(ack_d));

   axis_keep_snooper #(.DATA_WIDTH(64), .ADDR_WIDTH(2), .PESS(0)) dut_s (
      .clk(clk), .rst(rst), .sn_TDATA(tdata), .sn_TKEEP(tkeep), .sn_TVALID(tvalid),
      .sn_TREADY(tready), .sn_TLAST(tlast), .sn_addr(addr_s), .sn_wr_data(wdata_s),
      .sn_wr_en(wen_s), .sn_byte_inc(inc_s), .sn_len(len_s), .sn_trunc(trunc_s),
      .sn_done(done_s), .rdy_for_sn(rdy), .rdy_for_sn_ack(ack_s));

   axis_keep_snooper #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .PESS(1)) dut_p (
      .clk(clk), .rst(rst), .sn_TDATA(tdata), .sn_TKEEP(tkeep), .sn_TVALID(tvalid),
      .sn_TREADY(tready), .sn_TLAST(tlast), .sn_addr(addr_p), .sn_wr_data(wdata_p),
      .sn_wr_en(wen_p), .sn_byte_inc(inc_p), .sn_len(len_p), .sn_trunc(trunc_p),
      .sn_done(done_p), .rdy_for_sn(rdy), .rdy_for_sn_ack(ack_p));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic ev_t mk(input int c, input logic wr, input logic [8:0] a,
                              input logic [7:0] i, input logic [63:0] d, input logic dn,
                              input logic [15:0] l, input logic tr, input logic ak);
      ev_t e;
      e.cyc = c; e.wr = wr; e.addr = a; e.inc = i; e.data = d;
      e.dn = dn; e.len = l; e.tr = tr; e.ak = ak;
      return e;
   endfunction

   task automatic cmp_ev(input string who, input ev_t g, input ev_t e);
      chk({who, ".cycle"}, 64'(g.cyc), 64'(e.cyc));
      chk({who, ".wr_en"}, 64'(g.wr), 64'(e.wr));
      chk({who, ".done"}, 64'(g.dn), 64'(e.dn));
      chk({who, ".ack"}, 64'(g.ak), 64'(e.ak));
      if (e.wr) begin
         chk({who, ".addr"}, 64'(g.addr), 64'(e.addr));
         chk({who, ".byte_inc"}, 64'(g.inc), 64'(e.inc));
         chk({who, ".wr_data"}, g.data, e.data);
      end
      if (e.dn) begin
         chk({who, ".len"}, 64'(g.len), 64'(e.len));
         chk({who, ".trunc"}, 64'(g.tr), 64'(e.tr));
      end
   endtask

   // Registered-input instance sees beats one cycle late; claims in IDLE react to rdy directly.
   task automatic expect_ev(input logic [2:0] who, input int p_dly, input logic wr,
                            input int addr, input int inc, input logic dn, input int len,
                            input logic tr, input logic ak);
      ev_t e;
      e = mk(cyc, wr, 9'(addr), 8'(inc), cur_data, dn, 16'(len), tr, ak);
      if (who[0]) q_d.push_back(e);
      if (who[1]) q_s.push_back(e);
      if (who[2]) begin
         e.cyc = cyc + p_dly;
         q_p.push_back(e);
      end
   endtask

   always @(negedge clk) begin : mon_d
      ev_t g;
      if (wen_d || done_d || ack_d) begin
         g = mk(cyc, wen_d, addr_d, inc_d, wdata_d, done_d, len_d, trunc_d, ack_d);
         checks++;
         assert (q_d.size() != 0) else begin
            errors++;
            $error("FAIL dut_d.unexpected: observed event at cycle %0d expected none", cyc);
         end
         if (q_d.size() != 0) cmp_ev("dut_d", g, q_d.pop_front());
      end
   end

   always @(negedge clk) begin : mon_s
      ev_t g;
      if (wen_s || done_s || ack_s) begin
         g = mk(cyc, wen_s, {7'd0, addr_s}, inc_s, wdata_s, done_s, len_s, trunc_s, ack_s);
         checks++;
         assert (q_s.size() != 0) else begin
            errors++;
            $error("FAIL dut_s.unexpected: observed event at cycle %0d expected none", cyc);
         end
         if (q_s.size() != 0) cmp_ev("dut_s", g, q_s.pop_front());
      end
   end

   always @(negedge clk) begin : mon_p
      ev_t g;
      if (wen_p || done_p || ack_p) begin
         g = mk(cyc, wen_p, addr_p, inc_p, wdata_p, done_p, len_p, trunc_p, ack_p);
         checks++;
         assert (q_p.size() != 0) else begin
            errors++;
            $error("FAIL dut_p.unexpected: observed event at cycle %0d expected none", cyc);
         end
         if (q_p.size() != 0) cmp_ev("dut_p", g, q_p.pop_front());
      end
   end

   task automatic drive(input logic r_st, input logic v, input logic r, input logic l,
                        input logic [7:0] k, input logic rd);
      rst      = r_st;
      tvalid   = v;
      tready   = r;
      tlast    = l;
      tkeep    = k;
      rdy      = rd;
      cur_data = {$urandom, $urandom};
      tdata    = cur_data;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag, input bit all_inc);
      chk({tag, ".d.addr"}, 64'(addr_d), 64'd0);
      chk({tag, ".s.addr"}, 64'(addr_s), 64'd0);
      chk({tag, ".p.addr"}, 64'(addr_p), 64'd0);
      chk({tag, ".wr_en"}, {61'd0, wen_d, wen_s, wen_p}, 64'd0);
      chk({tag, ".done"}, {61'd0, done_d, done_s, done_p}, 64'd0);
      chk({tag, ".trunc"}, {61'd0, trunc_d, trunc_s, trunc_p}, 64'd0);
      chk({tag, ".ack"}, {61'd0, ack_d, ack_s, ack_p}, 64'd0);
      chk({tag, ".len"}, {16'd0, len_d, len_s, len_p}, 64'd0);
      chk({tag, ".p.byte_inc"}, 64'(inc_p), 64'd0);
      if (all_inc) chk({tag, ".ds.byte_inc"}, {48'd0, inc_d, inc_s}, 64'd0);
   endtask

   initial begin
      rst = 1'b1; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
      tkeep = 8'h00; rdy = 1'b0; tdata = '0; cur_data = '0;
      tick; tick;
      drive(0, 0, 0, 0, 8'h00, 0);
      @(negedge clk);
      check_reset("reset", 1'b1);
      tick;

      // claim mid-packet, skip its tail, capture FF,FF,0F
      drive(0, 1, 1, 0, 8'hFF, 0); tick;
      drive(0, 1, 1, 0, 8'hFF, 1); expect_ev(W_ALL, 0, 0, 0, 0, 0, 0, 0, 1); tick;
      drive(0, 1, 1, 1, 8'h0F, 0); tick;
      drive(0, 1, 1, 0, 8'hFF, 0); expect_ev(W_ALL, 1, 1, 0, 8, 0, 0, 0, 0); tick;
      drive(0, 1, 1, 0, 8'hFF, 0); expect_ev(W_ALL, 1, 1, 1, 8, 0, 0, 0, 0); tick;
      drive(0, 1, 1, 1, 8'h0F, 0); expect_ev(W_ALL, 1, 1, 2, 4, 1, 20, 0, 0); tick;
      drive(0, 0, 0, 0, 8'h00, 0); tick;

      // back-to-back 2-beat packets with rdy held high
      drive(0, 1, 1, 1, 8'hFF, 1); expect_ev(W_ALL, 0, 0, 0, 0, 0, 0, 0, 1); tick;
      drive(0, 1, 1, 0, 8'hFF, 1); expect_ev(W_ALL, 1, 1, 0, 8, 0, 0, 0, 0); tick;
      drive(0, 1, 1, 1, 8'hFF, 1); expect_ev(W_ALL, 1, 1, 1, 8, 1, 16, 0, 1); tick;
      drive(0, 1, 1, 0, 8'hFF, 1); expect_ev(W_ALL, 1, 1, 0, 8, 0, 0, 0, 0); tick;
      drive(0, 1, 1, 1, 8'hFF, 1); expect_ev(W_ALL, 1, 1, 1, 8, 1, 16, 0, 1); tick;

      // 6-beat packet: 4-word buffer truncates
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, 1, (i == 5), 8'hFF, 1);
         if (i < 5) begin
            expect_ev(W_D | W_P, 1, 1, i, 8, 0, 0, 0, 0);
            if (i < 4) expect_ev(W_S, 0, 1, i, 8, 0, 0, 0, 0);
         end else begin
            expect_ev(W_D | W_P, 1, 1, 5, 8, 1, 48, 0, 1);
            expect_ev(W_S, 0, 0, 0, 0, 1, 32, 1, 1);
         end
         tick;
      end

      // stalled TLAST then null TLAST beat
      drive(0, 1, 1, 0, 8'h0F, 1); expect_ev(W_ALL, 1, 1, 0, 4, 0, 0, 0, 0); tick;
      drive(0, 1, 0, 1, 8'hFF, 0); tick;
      drive(0, 1, 1, 1, 8'h00, 0); expect_ev(W_ALL, 1, 0, 0, 0, 1, 4, 0, 0); tick;
      drive(0, 0, 0, 0, 8'h00, 0); tick;
      drive(0, 0, 0, 0, 8'h00, 0); tick;

      // reset mid-capture
      drive(0, 1, 1, 1, 8'hFF, 1); expect_ev(W_ALL, 0, 0, 0, 0, 0, 0, 0, 1); tick;
      drive(0, 1, 1, 0, 8'hFF, 0); expect_ev(W_ALL, 1, 1, 0, 8, 0, 0, 0, 0); tick;
      drive(0, 1, 1, 0, 8'hFF, 0); expect_ev(W_D | W_S, 0, 1, 1, 8, 0, 0, 0, 0); tick;
      drive(1, 1, 1, 0, 8'hFF, 0); tick;
      drive(0, 1, 1, 0, 8'hFF, 0);
      @(negedge clk);
      check_reset("mid_rst", 1'b0);
      tick;
      drive(0, 1, 1, 0, 8'hFF, 1); expect_ev(W_ALL, 0, 0, 0, 0, 0, 0, 0, 1); tick;
      drive(0, 1, 1, 1, 8'hFF, 0); tick;
      drive(0, 1, 1, 0, 8'hFF, 0); expect_ev(W_ALL, 1, 1, 0, 8, 0, 0, 0, 0); tick;
      drive(0, 1, 1, 1, 8'h0F, 0); expect_ev(W_ALL, 1, 1, 1, 4, 1, 12, 0, 0); tick;
      drive(0, 0, 0, 0, 8'h00, 0); tick;
      drive(0, 0, 0, 0, 8'h00, 0); tick;
      drive(0, 0, 0, 0, 8'h00, 0); tick;

      chk("dut_d.pending", 64'(q_d.size()), 64'd0);
      chk("dut_s.pending", 64'(q_s.size()), 64'd0);
      chk("dut_p.pending", 64'(q_p.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
